// File: rtl/adc_sample_sequencer_pkg.sv
// Shared definitions for the ADC sample sequencer.
//   seq_state_e : scan FSM states (idle, start conversion, wait for FIN, write result)
//   CMD_*       : fixed fields of the SPI ADC command word
//   build_cmd   : assembles the command word for a given input channel
package adc_sample_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StConv  = 2'd2,
    StWrite = 2'd3
  } seq_state_e;

  localparam logic [3:0] CMD_PREFIX = 4'b0001;
  localparam logic       CMD_WRITE  = 1'b1;
  localparam logic [6:0] CMD_TAIL   = 7'b1000000;

  function automatic logic [15:0] build_cmd(input logic [1:0] chan_sel);
    return {CMD_PREFIX, CMD_WRITE, 2'b00, chan_sel, CMD_TAIL};
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Fixed-rate sample tick generator.
//   SYS_CLK : system clock
//   reset   : synchronous, active-high reset
//   on      : run enable; the counter is held at 0 while low
//   tick    : high for one cycle every TICK_DIV cycles while on
module sample_tick_gen #(
  parameter int unsigned TICK_DIV = 128
) (
  input  logic SYS_CLK,
  input  logic reset,
  input  logic on,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge SYS_CLK) begin
    if (reset || !on) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  // Gated by on so a counter parked at 0 can never look like a tick.
  assign tick = on && (count_q == LAST);

endmodule

// File: rtl/adc_sample_sequencer.sv
// ADC sample sequencer: on every sample tick, scans ADCs 0..NUM_ADC-1 one at a time over their
// SPI masters and writes each conversion result as one word into the sample FIFO.
//   SYS_CLK      : system clock
//   reset        : synchronous, active-high reset (aborts a frame immediately)
//   on           : run enable
//   chan_sel     : ADC input channel, placed in the command word at frame start
//   adc_fin      : FIN from each SPI ADC master
//   adc_data     : result buses, ADC i at [DBITS*i +: DBITS]
//   fifo_full    : sample FIFO full
//   adc_en       : ENA to each SPI ADC master, one-hot or zero
//   adc_cmd      : command word, common to all ADCs, stable for a whole frame
//   fifo_wr      : one-cycle FIFO write strobe
//   fifo_din     : FIFO write data (zero outside the write cycle)
//   busy         : frame in progress
//   overrun      : sticky, a result was dropped because the FIFO was full
//   late         : sticky, a tick arrived while a frame was still running
//   timeout_err  : sticky, a conversion never raised FIN within FIN_TIMEOUT cycles
//   sample_count : number of words written to the FIFO, wrapping
module adc_sample_sequencer
  import adc_sample_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 128,
  parameter int unsigned NUM_ADC     = 5,
  parameter int unsigned DBITS       = 16,
  parameter int unsigned FIN_TIMEOUT = 1024
) (
  input  logic                     SYS_CLK,
  input  logic                     reset,
  input  logic                     on,
  input  logic [1:0]               chan_sel,
  input  logic [NUM_ADC-1:0]       adc_fin,
  input  logic [DBITS*NUM_ADC-1:0] adc_data,
  input  logic                     fifo_full,
  output logic [NUM_ADC-1:0]       adc_en,
  output logic [15:0]              adc_cmd,
  output logic                     fifo_wr,
  output logic [DBITS-1:0]         fifo_din,
  output logic                     busy,
  output logic                     overrun,
  output logic                     late,
  output logic                     timeout_err,
  output logic [15:0]              sample_count
);

  localparam int unsigned IW = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;
  localparam int unsigned TW = $clog2(FIN_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ADC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(FIN_TIMEOUT - 1);

  seq_state_e          state_q;
  logic [IW-1:0]       idx_q;
  logic [TW-1:0]       tmo_q;
  logic [NUM_ADC-1:0]  fin_q;
  logic [DBITS-1:0]    cap_q;
  logic                tick;
  logic                fin_rise;
  logic                frame_done;
  logic [DBITS-1:0]    adc_word [NUM_ADC];

  sample_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .SYS_CLK (SYS_CLK),
    .reset   (reset),
    .on      (on),
    .tick    (tick)
  );

  for (genvar g = 0; g < NUM_ADC; g++) begin : g_word
    assign adc_word[g] = adc_data[DBITS*g +: DBITS];
  end

  assign fin_rise = adc_fin[idx_q] & ~fin_q[idx_q];
  // Dropping on lets the current conversion complete, then the frame stops.
  assign frame_done = (idx_q == LAST_IDX) || !on;

  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      tmo_q        <= '0;
      fin_q        <= '0;
      cap_q        <= '0;
      adc_en       <= '0;
      adc_cmd      <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      late         <= 1'b0;
      timeout_err  <= 1'b0;
      sample_count <= '0;
    end else begin
      fin_q <= adc_fin;
      // Ticks during a frame are not queued; the tick rate stays fixed.
      if (tick && (state_q != StIdle)) begin
        late <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            state_q <= StStart;
            idx_q   <= '0;
            adc_cmd <= build_cmd(chan_sel);
            busy    <= 1'b1;
          end
        end
        StStart: begin
          adc_en  <= NUM_ADC'(1) << idx_q;
          tmo_q   <= '0;
          state_q <= StConv;
        end
        StConv: begin
          if (fin_rise) begin
            cap_q   <= adc_word[idx_q];
            adc_en  <= '0;
            state_q <= StWrite;
          end else if (tmo_q == TMO_LAST) begin
            // Stuck converter: abandon it without a write and move on.
            adc_en      <= '0;
            timeout_err <= 1'b1;
            if (frame_done) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StStart;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StWrite: begin
          if (!fifo_full) begin
            sample_count <= sample_count + 16'd1;
          end else begin
            overrun <= 1'b1;
          end
          if (frame_done) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StStart;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The strobe is decoded from the state and gated directly by fifo_full, so a write can never
  // coincide with a full FIFO even if fifo_full changes during the write cycle.
  always_comb begin
    fifo_wr  = (state_q == StWrite) && !fifo_full;
    fifo_din = '0;
    if (fifo_wr) begin
      fifo_din = cap_q;
    end
  end

endmodule
